// File: rtl/prescaler0_ctrl.sv
// prescaler0_ctrl -- shared timer prescaler with GTCCR (TSM/PSRSYNC) control.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   cs0, cs1, cs3, cs4    timer clock-select fields; 3'b010..3'b101 need the prescaler
//   gtccr_we/gtccr_wdata  GTCCR write strobe and data (bit7 TSM, bit0 PSRSYNC)
//   gtccr_rdata           GTCCR readback {TSM, 6'b0, PSRSYNC}
//   clk*en                one-cycle divide-by-8/64/256/1024 enable pulses
//   presc_cnt             prescaler count
//   presc_state           00 IDLE, 01 RUN, 10 HALT
//
// Build option: PRESC_AUTO_GATE_EN adds the IDLE state, which parks the
// counter while no timer selects a prescaled clock. Without it the counter
// runs continuously except in HALT.

module prescaler0_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cs0,
  input  logic [2:0] cs1,
  input  logic [2:0] cs3,
  input  logic [2:0] cs4,
  input  logic       gtccr_we,
  input  logic [7:0] gtccr_wdata,
  output logic [7:0] gtccr_rdata,
  output logic       clk8en,
  output logic       clk64en,
  output logic       clk256en,
  output logic       clk1024en,
  output logic [9:0] presc_cnt,
  output logic [1:0] presc_state
);

`ifdef PRESC_AUTO_GATE_EN
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;
  localparam state_t RESET_STATE = IDLE;
`else
  typedef enum logic [1:0] {
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;
  localparam state_t RESET_STATE = RUN;
`endif

  state_t     state;
  state_t     state_nxt;
  logic       tsm;
  logic       tsm_nxt;
  logic       psrsync;
  logic       psrsync_nxt;
  logic       psr_set;
  logic [9:0] cnt;
  logic [9:0] cnt_nxt;
  logic       run;
  logic       unused_bits;

  function automatic logic cs_prescaled(input logic [2:0] cs);
    return (cs >= 3'b010) && (cs <= 3'b101);
  endfunction

`ifdef PRESC_AUTO_GATE_EN
  logic use_presc;
  assign use_presc   = cs_prescaled(cs0) | cs_prescaled(cs1)
                     | cs_prescaled(cs3) | cs_prescaled(cs4);
  assign unused_bits = ^gtccr_wdata[6:1];
`else
  assign unused_bits = ^{gtccr_wdata[6:1], cs0, cs1, cs3, cs4};
`endif

  // GTCCR flags
  always_comb begin
    psr_set     = gtccr_we & gtccr_wdata[0];
    tsm_nxt     = gtccr_we ? gtccr_wdata[7] : tsm;
    psrsync_nxt = psrsync;
    if (psr_set)
      psrsync_nxt = 1'b1;
    else if (psrsync && !tsm)
      psrsync_nxt = 1'b0;
  end

  // HALT tracks PSRSYNC exactly, so the next state follows the next flag
  // value; any non-HALT successor is chosen purely by the gating condition.
  always_comb begin
    state_nxt = state;
    if (psrsync_nxt) begin
      state_nxt = HALT;
    end else begin
`ifdef PRESC_AUTO_GATE_EN
      state_nxt = use_presc ? RUN : IDLE;
`else
      state_nxt = RUN;
`endif
    end
  end

  // Count only while staying in RUN; any entry to RUN starts from zero.
  always_comb begin
    cnt_nxt = '0;
    if (state == RUN && state_nxt == RUN)
      cnt_nxt = cnt + 10'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RESET_STATE;
      tsm     <= 1'b0;
      psrsync <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      tsm     <= tsm_nxt;
      psrsync <= psrsync_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign run         = (state == RUN);
  assign clk8en      = run & (&cnt[2:0]);
  assign clk64en     = run & (&cnt[5:0]);
  assign clk256en    = run & (&cnt[7:0]);
  assign clk1024en   = run & (&cnt);
  assign presc_cnt   = cnt;
  assign presc_state = state;
  assign gtccr_rdata = {tsm, 6'b000000, psrsync};

endmodule

// File: tb/tb_prescaler0_ctrl.sv
// tb_prescaler0_ctrl -- directed stimulus with a cycle-tagged scoreboard for
// prescaler0_ctrl. Expectations follow PRESC_AUTO_GATE_EN if defined.

module tb_prescaler0_ctrl;

`ifdef PRESC_AUTO_GATE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;
  localparam logic [1:0] ST_RST  = AUTO ? ST_IDLE : ST_RUN;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cs0, cs1, cs3, cs4;
  logic       gtccr_we;
  logic [7:0] gtccr_wdata;
  logic [7:0] gtccr_rdata;
  logic       clk8en, clk64en, clk256en, clk1024en;
  logic [9:0] presc_cnt;
  logic [1:0] presc_state;

  prescaler0_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cs0         (cs0),
    .cs1         (cs1),
    .cs3         (cs3),
    .cs4         (cs4),
    .gtccr_we    (gtccr_we),
    .gtccr_wdata (gtccr_wdata),
    .gtccr_rdata (gtccr_rdata),
    .clk8en      (clk8en),
    .clk64en     (clk64en),
    .clk256en    (clk256en),
    .clk1024en   (clk1024en),
    .presc_cnt   (presc_cnt),
    .presc_state (presc_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [23:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // en is {clk1024en, clk256en, clk64en, clk8en}
  task automatic push(input int c, input string n, input logic [9:0] cnt,
                      input logic [1:0] st, input logic [3:0] en,
                      input logic [7:0] rd);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.exp  = {cnt, st, en, rd};
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: sample just after the falling edge, compare every expectation
  // tagged with the current cycle.
  initial begin
    logic [23:0] act;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      act = {presc_cnt, presc_state, clk1024en, clk256en, clk64en, clk8en, gtccr_rdata};
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        vectors++;
        if (e.cyc < cyc) begin
          miscompares++;
          $display("FAIL %s: expectation for cycle %0d missed, now cycle %0d", e.name, e.cyc, cyc);
        end else if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s @%0d: got cnt=%0d st=%b en=%b rd=%h, required cnt=%0d st=%b en=%b rd=%h",
                   e.name, cyc, act[23:14], act[13:12], act[11:8], act[7:0],
                   e.exp[23:14], e.exp[13:12], e.exp[11:8], e.exp[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  int c0, base, base2, base3, base4, base5, r, t;

  initial begin
    rst = 1'b1;
    cs0 = 3'b000; cs1 = 3'b000; cs3 = 3'b000; cs4 = 3'b000;
    gtccr_we = 1'b0; gtccr_wdata = 8'h00;

    // Reset and first counting run with cs0 = 3'b010
    repeat (3) @(negedge clk);
    cs0 = 3'b010;
    push(cyc, "reset_state", 10'd0, ST_RST, 4'b0000, 8'h00);
    @(negedge clk);
    rst  = 1'b0;
    c0   = cyc;
    base = c0 + (AUTO ? 1 : 0);
    if (AUTO) push(c0, "rel_idle", 10'd0, ST_IDLE, 4'b0000, 8'h00);
    push(base,        "run_start", 10'd0,    ST_RUN, 4'b0000, 8'h00);
    push(base + 7,    "clk8_1",    10'd7,    ST_RUN, 4'b0001, 8'h00);
    push(base + 8,    "clk8_off",  10'd8,    ST_RUN, 4'b0000, 8'h00);
    push(base + 15,   "clk8_2",    10'd15,   ST_RUN, 4'b0001, 8'h00);
    push(base + 63,   "clk64",     10'd63,   ST_RUN, 4'b0011, 8'h00);
    push(base + 255,  "clk256",    10'd255,  ST_RUN, 4'b0111, 8'h00);
    push(base + 1023, "all_en",    10'd1023, ST_RUN, 4'b1111, 8'h00);
    push(base + 1024, "wrap",      10'd0,    ST_RUN, 4'b0000, 8'h00);
    push(base + 1031, "clk8_wrap", 10'd7,    ST_RUN, 4'b0001, 8'h00);

    // PSRSYNC pulse with TSM=0 at count 300
    base2 = base + 1024 + 300;
    wait_until(base2);
    gtccr_we = 1'b1; gtccr_wdata = 8'h01;
    push(base2,     "pre_psr",   10'd300, ST_RUN,  4'b0000, 8'h00);
    push(base2 + 1, "psr_halt",  10'd0,   ST_HALT, 4'b0000, 8'h01);
    push(base2 + 2, "psr_clear", 10'd0,   ST_RUN,  4'b0000, 8'h00);
    push(base2 + 3, "psr_cnt1",  10'd1,   ST_RUN,  4'b0000, 8'h00);
    push(base2 + 9, "psr_clk8",  10'd7,   ST_RUN,  4'b0001, 8'h00);
    @(negedge clk);
    gtccr_we = 1'b0;

    // TSM hold: write 8'h81 while enables pulse, hold, then release
    base3 = base2 + 65;
    wait_until(base3);
    gtccr_we = 1'b1; gtccr_wdata = 8'h81;
    push(base3,     "psr_same_en", 10'd63, ST_RUN,  4'b0011, 8'h00);
    push(base3 + 1, "tsm_halt",    10'd0,  ST_HALT, 4'b0000, 8'h81);
    @(negedge clk);
    gtccr_we = 1'b0;
    wait_until(base3 + 5);
    gtccr_we = 1'b1; gtccr_wdata = 8'h80;
    cs0 = 3'b000;
    push(base3 + 6, "bit0_0_keep", 10'd0, ST_HALT, 4'b0000, 8'h81);
    @(negedge clk);
    gtccr_we = 1'b0;
    wait_until(base3 + 10);
    cs0 = 3'b010;
    push(base3 + 10, "cs_in_halt", 10'd0, ST_HALT, 4'b0000, 8'h81);
    push(base3 + 20, "tsm_hold20", 10'd0, ST_HALT, 4'b0000, 8'h81);
    wait_until(base3 + 20);
    gtccr_we = 1'b1; gtccr_wdata = 8'h00;
    push(base3 + 21, "tsm0_still", 10'd0, ST_HALT, 4'b0000, 8'h01);
    push(base3 + 22, "tsm_resume", 10'd0, ST_RUN,  4'b0000, 8'h00);
    push(base3 + 29, "tsm_clk8",   10'd7, ST_RUN,  4'b0001, 8'h00);
    @(negedge clk);
    gtccr_we = 1'b0;

    // Simultaneous TSM=0 / PSRSYNC=1 write while TSM=1
    base4 = base3 + 30;
    wait_until(base4);
    gtccr_we = 1'b1; gtccr_wdata = 8'h81;
    push(base4,     "pre_tsm2",  10'd8, ST_RUN,  4'b0000, 8'h00);
    push(base4 + 1, "tsm2_halt", 10'd0, ST_HALT, 4'b0000, 8'h81);
    @(negedge clk);
    gtccr_we = 1'b0;
    wait_until(base4 + 3);
    gtccr_we = 1'b1; gtccr_wdata = 8'h01;
    push(base4 + 3, "tsm2_hold",  10'd0, ST_HALT, 4'b0000, 8'h81);
    push(base4 + 4, "simul_once", 10'd0, ST_HALT, 4'b0000, 8'h01);
    push(base4 + 5, "simul_clr",  10'd0, ST_RUN,  4'b0000, 8'h00);
    push(base4 + 6, "simul_cnt1", 10'd1, ST_RUN,  4'b0000, 8'h00);
    @(negedge clk);
    gtccr_we = 1'b0;

    // No timer using the prescaler (just outside the 010..101 range)
    base5 = base4 + 6;
    wait_until(base5);
    cs0 = 3'b001; cs1 = 3'b110; cs3 = 3'b111; cs4 = 3'b000;
    push(base5 + 1, "unuse_1", AUTO ? 10'd0 : 10'd2, AUTO ? ST_IDLE : ST_RUN, 4'b0000, 8'h00);
    push(base5 + 2, "unuse_2", AUTO ? 10'd0 : 10'd3, AUTO ? ST_IDLE : ST_RUN, 4'b0000, 8'h00);
    wait_until(base5 + 2);
    cs3 = 3'b101;
    push(base5 + 3, "reuse_1", AUTO ? 10'd0 : 10'd4, ST_RUN, 4'b0000, 8'h00);
    push(base5 + 4, "reuse_2", AUTO ? 10'd1 : 10'd5, ST_RUN, 4'b0000, 8'h00);

    // Asynchronous reset while clk64en is high
    r = base5 + 3;
    t = r + 63 - (AUTO ? 0 : 4);
    wait_until(t - 1);
    push(t - 1, "pre_rst", 10'd62, ST_RUN, 4'b0000, 8'h00);
    wait_until(t);
    rst = 1'b1;
    push(t,     "rst_immed", 10'd0, ST_RST, 4'b0000, 8'h00);
    push(t + 2, "rst_held",  10'd0, ST_RST, 4'b0000, 8'h00);
    wait_until(t + 3);
    rst = 1'b0;
    push(t + 3, "rst_rel",   10'd0, ST_RST, 4'b0000, 8'h00);
    push(t + 4, "post_rst",  AUTO ? 10'd0 : 10'd1, ST_RUN, 4'b0000, 8'h00);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
